pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_pkg.sv | 36 +++
 rtl/tick_divider.sv | 41 ++++
 rtl/pwm_fade_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : pwm_pkg                                                  |
// | Brief   : Shared constants, state encoding and saturating helpers  |
// |           for the PWM fade controller.                             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pwm_pkg;

   localparam int PWM_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      HOLD = 2'd2,
      DOWN = 2'd3
   } fade_state_e;

   // One extra bit of headroom so the step can never wrap the duty value.
   function automatic logic [PWM_W-1:0] sat_add(input logic [PWM_W-1:0] v,
                                                input logic [PWM_W-1:0] s,
                                                input logic [PWM_W-1:0] p);
      logic [PWM_W:0] sum;
      sum = {1'b0, v} + {1'b0, s};
      return (sum >= {1'b0, p}) ? p : sum[PWM_W-1:0];
   endfunction

   function automatic logic [PWM_W-1:0] sat_sub(input logic [PWM_W-1:0] v,
                                                input logic [PWM_W-1:0] s);
      logic [PWM_W:0] diff;
      diff = {1'b0, v} - {1'b0, s};
      return diff[PWM_W] ? '0 : diff[PWM_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tick_divider                                             |
// | Brief   : Fade-tick prescaler; one-cycle tick every DIV cycles     |
// |           after clr is released.                                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tick_divider #(
   parameter int DIV = 262144
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = !clr && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : pwm_fade_ctrl                                            |
// | Brief   : Ramps a PWM duty 0 -> PEAK -> 0 in STEP increments, one  |
// |           write strobe per update. Define PWM_FADE_HOLD_EN to     |
// |           dwell at PEAK for HOLD_TICKS ticks before ramping down.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pwm_fade_ctrl
   import pwm_pkg::*;
#(
   parameter int DIV        = 262144,
   parameter int PEAK       = 128,
   parameter int STEP       = 1,
   parameter int HOLD_TICKS = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             stop,
   input  logic             loop,
   output logic             pwm_en,
   output logic [PWM_W-1:0] pwm_value,
   output logic             busy,
   output logic             cycle_done
);

   localparam logic [PWM_W-1:0] PEAK_V = PWM_W'(PEAK);
   localparam logic [PWM_W-1:0] STEP_V = PWM_W'(STEP);

   if (DIV < 2 || PEAK < 1 || PEAK > 255 || STEP < 1 || STEP > PEAK ||
       HOLD_TICKS < 1 || HOLD_TICKS > 255) begin : g_bad_cfg
      $error("pwm_fade_ctrl: parameter out of range");
   end

   fade_state_e      state_q, state_d;
   logic [PWM_W-1:0] value_q, value_d;
   logic             en_q, en_d;
   logic             done_q, done_d;
   logic             tick;
   logic             step_down;
   logic [PWM_W-1:0] inc_val;
   logic [PWM_W-1:0] dec_val;

`ifdef PWM_FADE_HOLD_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
   logic [7:0] hold_q, hold_d;
`endif

   tick_divider #(
      .DIV (DIV)
   ) u_tick (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (state_q == IDLE),
      .tick (tick)
   );

   assign inc_val    = sat_add(value_q, STEP_V, PEAK_V);
   assign dec_val    = sat_sub(value_q, STEP_V);
   assign busy       = (state_q != IDLE);
   assign pwm_en     = en_q;
   assign pwm_value  = value_q;
   assign cycle_done = done_q;

   always_comb begin
      state_d   = state_q;
      value_d   = value_q;
      en_d      = 1'b0;
      done_d    = 1'b0;
      step_down = 1'b0;
`ifdef PWM_FADE_HOLD_EN
      hold_d    = hold_q;
`endif
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d = UP;
               value_d = '0;
               en_d    = 1'b1;
            end
         end
         UP: begin
            if (tick) begin
               value_d = inc_val;
               en_d    = 1'b1;
               if (inc_val == PEAK_V) begin
`ifdef PWM_FADE_HOLD_EN
                  state_d = HOLD;
                  hold_d  = '0;
`else
                  state_d = DOWN;
`endif
               end
            end
         end
`ifdef PWM_FADE_HOLD_EN
         HOLD: begin
            if (tick) begin
               if (hold_q == HOLD_LAST) begin
                  step_down = 1'b1;
               end else begin
                  hold_d = hold_q + 8'd1;
               end
            end
         end
`endif
         DOWN: begin
            step_down = tick;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (step_down) begin
         value_d = dec_val;
         en_d    = 1'b1;
         state_d = DOWN;
         if (dec_val == '0) begin
            done_d  = 1'b1;
            state_d = loop ? UP : IDLE;
         end
      end

      // Abort outranks any tick arriving in the same cycle.
      if (stop && state_q != IDLE) begin
         state_d = IDLE;
         value_d = '0;
         en_d    = 1'b1;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         value_q <= '0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         en_q    <= en_d;
         done_q  <= done_d;
      end
   end

`ifdef PWM_FADE_HOLD_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// Self-checking bench for pwm_fade_ctrl: a PEAK=8 and a PEAK=7 instance
// share one stimulus stream (DIV=4, STEP=2, HOLD_TICKS=3).
module tb_pwm_fade_ctrl;

   localparam int DIV  = 4;
   localparam int STEP = 2;
   localparam int HOLD = 3;
`ifdef PWM_FADE_HOLD_EN
   localparam int HX = (HOLD - 1) * DIV;
`else
   localparam int HX = 0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       loop = 1'b0;
   logic       en_a, busy_a, done_a;
   logic       en_b, busy_b, done_b;
   logic [7:0] val_a, val_b;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       start;
      logic       stop;
      logic       loop;
      logic       en;
      logic [7:0] val;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl[11];

   pwm_fade_ctrl #(.DIV(DIV), .PEAK(8), .STEP(STEP), .HOLD_TICKS(HOLD)) dut_a (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop), .loop(loop),
      .pwm_en(en_a), .pwm_value(val_a), .busy(busy_a), .cycle_done(done_a)
   );

   pwm_fade_ctrl #(.DIV(DIV), .PEAK(7), .STEP(STEP), .HOLD_TICKS(HOLD)) dut_b (
      .CLK(CLK), .RST(RST), .start(start), .stop(stop), .loop(loop),
      .pwm_en(en_b), .pwm_value(val_b), .busy(busy_b), .cycle_done(done_b)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_all_a(input string nm, input logic en, input logic [7:0] v,
                            input logic b, input logic d);
      chk({nm, "_en"},   32'(en_a),   32'(en));
      chk({nm, "_val"},  32'(val_a),  32'(v));
      chk({nm, "_busy"}, 32'(busy_a), 32'(b));
      chk({nm, "_done"}, 32'(done_a), 32'(d));
   endtask

   // Start a fade and check every cycle until the final write of 0.
   task automatic run_fade(input string tag, input logic lp);
      int   exp_a[9] = '{0, 2, 4, 6, 8, 6, 4, 2, 0};
      int   exp_b[9] = '{0, 2, 4, 6, 7, 5, 3, 1, 0};
      int   last;
      int   k;
      logic wr;
      last  = DIV * 8 + HX;
      k     = 0;
      loop  = lp;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c <= last; c++) begin
         if (c > 0) step();
         wr = (k < 9) && (c == DIV * k + ((k >= 5) ? HX : 0));
         chk($sformatf("%s_c%0d_en_a", tag, c), 32'(en_a), 32'(wr));
         chk($sformatf("%s_c%0d_en_b", tag, c), 32'(en_b), 32'(wr));
         if (wr) begin
            chk($sformatf("%s_w%0d_val_a", tag, k), 32'(val_a), 32'(exp_a[k]));
            chk($sformatf("%s_w%0d_val_b", tag, k), 32'(val_b), 32'(exp_b[k]));
            k++;
         end
         chk($sformatf("%s_c%0d_done_a", tag, c), 32'(done_a), 32'(c == last));
         chk($sformatf("%s_c%0d_done_b", tag, c), 32'(done_b), 32'(c == last));
         chk($sformatf("%s_c%0d_busy_a", tag, c), 32'(busy_a), 32'(lp || (c < last)));
      end
   endtask

   initial begin
      // {start, stop, loop, en, val, busy, done}
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};

      #7;
      chk_all_a("reset_held", 1'b0, 8'd0, 1'b0, 1'b0);
      step();
      RST = 1'b0;

      for (int i = 0; i < 11; i++) begin
         start = tbl[i].start;
         stop  = tbl[i].stop;
         loop  = tbl[i].loop;
         step();
         chk_all_a($sformatf("vec%0d", i), tbl[i].en, tbl[i].val, tbl[i].busy, tbl[i].done);
      end
      start = 1'b0;
      stop  = 1'b0;
      loop  = 1'b0;

      // Abort right after the write of 4.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 2 * DIV; c++) step();
      chk_all_a("abort_pre", 1'b1, 8'd4, 1'b1, 1'b0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_all_a("abort", 1'b1, 8'd0, 1'b0, 1'b0);
      step();
      chk_all_a("abort_after", 1'b0, 8'd0, 1'b0, 1'b0);

      run_fade("fade", 1'b0);
      for (int c = 0; c < 6; c++) begin
         step();
         chk($sformatf("post_fade%0d_en", c), 32'(en_a), 32'd0);
         chk($sformatf("post_fade%0d_busy", c), 32'(busy_a), 32'd0);
      end

      run_fade("loop", 1'b1);
      for (int c = 1; c <= DIV; c++) begin
         step();
         chk($sformatf("loop_re%0d_en", c), 32'(en_a), 32'(c == DIV));
         chk($sformatf("loop_re%0d_busy", c), 32'(busy_a), 32'd1);
         chk($sformatf("loop_re%0d_done", c), 32'(done_a), 32'd0);
      end
      chk("loop_re_val", 32'(val_a), 32'd2);
      loop = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_all_a("loop_stop", 1'b1, 8'd0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of UP.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= DIV + 1; c++) step();
      chk("rst_pre_val", 32'(val_a), 32'd2);
      #3;
      RST = 1'b1;
      #1;
      chk_all_a("rst_async", 1'b0, 8'd0, 1'b0, 1'b0);
      step();
      RST = 1'b0;
      for (int c = 0; c < 3 * DIV; c++) begin
         step();
         chk($sformatf("rst_rel%0d_busy", c), 32'(busy_a), 32'd0);
         chk($sformatf("rst_rel%0d_en", c), 32'(en_a), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
